// File: rtl/x_arb_pkg.sv
// Types and helpers shared by the switch arbiters: lock FSM encoding,
// index width sizing and a onehot-to-index encoder.
package x_arb_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} lock_st_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int IDX_W_DEF = idx_w(N_REQ_DEF);
  typedef logic [IDX_W_DEF-1:0] idx_t;

  // OR of set-bit positions; exact for onehot0 inputs of up to 32 bits.
  function automatic int oh2idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) r = r | i;
    return r;
  endfunction

endpackage

// File: rtl/x_rr_pick.sv
// Combinational round-robin pick: lowest requester above ptr, else lowest overall.
module x_rr_pick
  import x_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] masked, pick_m, pick_a;

  always_comb begin
    masked = '0;
    pick_m = '0;
    pick_a = '0;
    for (int i = 0; i < N; i++)
      masked[i] = req[i] & (i > int'(ptr));
    // Scan high to low so the lowest set index is the one left standing.
    for (int i = N-1; i >= 0; i--) begin
      if (masked[i]) begin
        pick_m    = '0;
        pick_m[i] = 1'b1;
      end
      if (req[i]) begin
        pick_a    = '0;
        pick_a[i] = 1'b1;
      end
    end
    gnt = (|masked) ? pick_m : pick_a;
  end

endmodule

// File: rtl/x_rr_arb_mux.sv
// N-input round-robin arbiter + payload mux with packet lock and a
// one-entry registered output stage.
module x_rr_arb_mux
  import x_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int D_WIDTH  = 16,
  parameter  int LOCK_PKT = 1,
  localparam int IDX_W    = idx_w(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_rdy,
  output logic                       out_vld,
  output logic                       out_last,
  output logic [D_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]           out_id,
  input  logic                       out_rdy,
  output logic                       locked
);

  lock_st_e           st;
  logic [IDX_W-1:0]   ptr, lock_id, idx;
  logic [N_REQ-1:0]   rr_gnt, lock_oh, gnt;
  logic               slot_free, acc, sel_last;
  logic [D_WIDTH-1:0] sel_data;

  x_rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
    .req (req_vld),
    .ptr (ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    lock_oh = '0;
    for (int i = 0; i < N_REQ; i++)
      lock_oh[i] = (lock_id == IDX_W'(i));
  end

  assign slot_free = ~out_vld | out_rdy;
  // Grant is forced off while reset is held so no source sees ready.
  assign gnt       = rst ? '0 : ((st == ST_LOCKED) ? lock_oh : rr_gnt);
  assign req_rdy   = gnt & {N_REQ{slot_free}};
  assign acc       = (|(gnt & req_vld)) & slot_free;
  assign idx       = IDX_W'(oh2idx(32'(gnt)));
  assign sel_last  = |(gnt & req_last);
  assign locked    = (st == ST_LOCKED);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++)
      sel_data = sel_data | (req_data[i*D_WIDTH +: D_WIDTH] & {D_WIDTH{gnt[i]}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      st       <= ST_IDLE;
      lock_id  <= '0;
      ptr      <= IDX_W'(N_REQ-1);
    end else if (acc) begin
      out_vld  <= 1'b1;
      out_last <= sel_last;
      out_data <= sel_data;
      out_id   <= idx;
      if (LOCK_PKT != 0) begin
        st <= sel_last ? ST_IDLE : ST_LOCKED;
        if (!sel_last) lock_id <= idx;
      end
      if (LOCK_PKT == 0 || sel_last) ptr <= idx;
    end else if (slot_free) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_x_rr_arb_mux.sv
// Directed bench: one packet-locking instance and one per-beat instance.
module tb_x_rr_arb_mux;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_vld, req_last, req_rdy;
  logic [3:0][15:0] dat;
  logic             out_vld, out_last, out_rdy, locked;
  logic [15:0]      out_data;
  logic [1:0]       out_id;

  logic [3:0]       b_vld, b_last, b_rdy;
  logic [3:0][15:0] b_dat;
  logic             b_out_vld, b_out_last, b_locked;
  logic [15:0]      b_out_data;
  logic [1:0]       b_out_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  x_rr_arb_mux #(.N_REQ(4), .D_WIDTH(16), .LOCK_PKT(1)) u_dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_last(req_last), .req_data(dat),
    .req_rdy(req_rdy), .out_vld(out_vld), .out_last(out_last), .out_data(out_data),
    .out_id(out_id), .out_rdy(out_rdy), .locked(locked)
  );

  x_rr_arb_mux #(.N_REQ(4), .D_WIDTH(16), .LOCK_PKT(0)) u_dut_nl (
    .clk(clk), .rst(rst), .req_vld(b_vld), .req_last(b_last), .req_data(b_dat),
    .req_rdy(b_rdy), .out_vld(b_out_vld), .out_last(b_out_last), .out_data(b_out_data),
    .out_id(b_out_id), .out_rdy(1'b1), .locked(b_locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output beat must not change while stalled downstream.
  bit          hold_pend = 0;
  logic [15:0] hold_data;
  logic [1:0]  hold_id;
  always @(negedge clk) begin
    if (rst) hold_pend = 0;
    else begin
      if (hold_pend) begin
        chk("hold_data", out_data, hold_data);
        chk("hold_id", out_id, hold_id);
      end
      hold_pend = out_vld & ~out_rdy;
      hold_data = out_data;
      hold_id   = out_id;
    end
  end

  initial begin
    rst = 1'b1; out_rdy = 1'b1;
    req_vld = '0; req_last = '0;
    for (int i = 0; i < 4; i++) dat[i] = 16'hC0D0 + 16'(i);
    b_vld = '0; b_last = '0;
    for (int i = 0; i < 4; i++) b_dat[i] = 16'hB000 + 16'(i);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_locked", locked, 0);
    chk("rst_id", out_id, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);

    // Fairness with single-beat packets on every input
    req_vld = 4'b1111; req_last = 4'b1111;
    #1 chk("first_rdy", req_rdy, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_id", out_id, k % 4);
      chk("rr_vld", out_vld, 1);
      chk("rr_data", out_data, 32'hC0D0 + (k % 4));
    end
    req_vld = '0;
    tick();
    chk("idle_vld", out_vld, 0);

    // Packet lock: in1 three beats while in0/in2 wait
    req_vld = 4'b0111; req_last = 4'b0101; dat[1] = 16'h1000;
    tick();
    chk("pk0_id", out_id, 1); chk("pk0_data", out_data, 16'h1000);
    chk("pk0_lock", locked, 1); chk("pk0_last", out_last, 0);
    dat[1] = 16'h1001;
    #1 chk("pk_rdy", req_rdy, 4'b0010);
    tick();
    chk("pk1_id", out_id, 1); chk("pk1_data", out_data, 16'h1001); chk("pk1_lock", locked, 1);
    dat[1] = 16'h1002; req_last = 4'b0111;
    tick();
    chk("pk2_id", out_id, 1); chk("pk2_data", out_data, 16'h1002);
    chk("pk2_last", out_last, 1); chk("pk2_lock", locked, 0);
    req_vld = 4'b0101;
    tick();
    chk("pk_next2", out_id, 2);
    req_vld = 4'b0001;
    tick();
    chk("pk_next0", out_id, 0);
    req_vld = '0;
    tick();

    // Backpressure
    req_vld = 4'b0100; req_last = 4'b1111; dat[2] = 16'h2A2A; dat[3] = 16'h3C3C;
    tick();
    chk("bp_id", out_id, 2); chk("bp_data", out_data, 16'h2A2A);
    out_rdy = 1'b0; dat[2] = 16'h2B2B; req_vld = 4'b1100;
    #1 chk("bp_rdy0", req_rdy, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_vld", out_vld, 1);
      chk("bp_hold_data", out_data, 16'h2A2A);
      chk("bp_hold_id", out_id, 2);
      chk("bp_hold_rdy", req_rdy, 4'b0000);
    end
    out_rdy = 1'b1;
    #1 chk("bp_rel_rdy", req_rdy, 4'b1000);
    tick();
    chk("bp_rel_id", out_id, 3); chk("bp_rel_data", out_data, 16'h3C3C);
    req_vld = '0;
    tick();

    // Source bubble while in3 holds the lock
    req_vld = 4'b0001; req_last = 4'b0001;
    tick();
    chk("sb_pre", out_id, 0);
    req_vld = 4'b1001; req_last = 4'b0001;
    tick();
    chk("sb_id", out_id, 3); chk("sb_lock", locked, 1);
    req_vld = 4'b0001;
    #1 chk("sb_rdy", req_rdy, 4'b1000);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("sb_bubble", out_vld, 0);
      chk("sb_lock_hold", locked, 1);
    end
    req_vld = 4'b1001; req_last = 4'b1001;
    tick();
    chk("sb_last_id", out_id, 3); chk("sb_unlock", locked, 0);
    req_vld = 4'b0001;
    tick();
    chk("sb_then0", out_id, 0);

    // Async reset mid-packet
    req_vld = 4'b0010; req_last = 4'b0000;
    tick();
    chk("ar_lock_pre", locked, 1);
    #3 rst = 1'b1;
    #1;
    chk("ar_vld", out_vld, 0); chk("ar_lock", locked, 0);
    chk("ar_rdy", req_rdy, 4'b0000); chk("ar_id", out_id, 0);
    tick();
    rst = 1'b0;
    req_vld = 4'b1111; req_last = 4'b1111;
    #1 chk("ar_first_rdy", req_rdy, 4'b0001);
    tick();
    chk("ar_first_id", out_id, 0); chk("ar_first_vld", out_vld, 1);
    req_vld = '0;

    // Per-beat arbitration instance
    b_vld = 4'b0011; b_last = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("nl_id", b_out_id, k % 2);
      chk("nl_vld", b_out_vld, 1);
      chk("nl_lock", b_locked, 0);
    end
    chk("nl_data", b_out_data, 16'hB001);
    b_vld = 4'b1001;
    tick(); chk("nl_wrap3", b_out_id, 3);
    tick(); chk("nl_wrap0", b_out_id, 0);
    tick(); chk("nl_wrap3b", b_out_id, 3);
    b_vld = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
